row_render: RTL and testbench

- Downstream consumer of the wall tracer's per-row result (side, size, texture column).
- At each hmax it latches the new result and runs a short sequential divider to get the texture step.
- It then paints one scanline as a horizontal wall span centred on column 320, with background colours on either side.
- It drives a texture ROM address (u,v), takes the texel back, and outputs registered 6-bit RGB (2 bits per channel).

---
 rtl/row_render.sv | 193 +++++++++++++++++++
 tb/tb_row_render.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/row_render.sv
// row_render: paints one scanline as a wall span centred on CENTRE, flanked by sky (left) and floor (right).
// Latency: o_rgb is registered, one clock after hpos; o_tex_u/o_tex_v are combinational from internal state.
// Backpressure: none; the block free-runs on the pixel clock and restarts its per-line work on every hmax.
//
// Ports:
//   clk, reset        pixel clock, synchronous active-high reset
//   hpos, visible     beam position and active-area flag
//   hmax              last clock of the line; i_side/i_size/i_tex_u are captured on it
//   i_texel           texture ROM data for (o_tex_u, o_tex_v), same cycle
//   o_tex_u, o_tex_v  texture ROM address
//   o_rgb             registered pixel colour {R[1:0],G[1:0],B[1:0]}
//
// Build option: define ROW_RENDER_TEXTURE_EN to include the step divider, the texture
// accumulator and the texel path. Without it, wall pixels use the flat side colours and
// the ROM address outputs are held at zero.

module row_render #(
    parameter logic [9:0] CENTRE    = 10'd320,
    parameter logic [9:0] SEED_COL  = 10'd24,
    parameter logic [5:0] SKY_RGB   = 6'b00_00_01,
    parameter logic [5:0] FLOOR_RGB = 6'b01_01_01,
    parameter logic [5:0] WALL0_RGB = 6'b11_00_00,
    parameter logic [5:0] WALL1_RGB = 6'b01_00_00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hpos,
    input  logic        visible,
    input  logic        hmax,
    input  logic        i_side,
    input  logic [10:0] i_size,
    input  logic [5:0]  i_tex_u,
    input  logic [5:0]  i_texel,
    output logic [5:0]  o_tex_u,
    output logic [5:0]  o_tex_v,
    output logic [5:0]  o_rgb
);

`ifdef ROW_RENDER_TEXTURE_EN
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DIV  = 2'd1;
    localparam logic [1:0] S_SEED = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;
`else
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WALL = 2'd1;
`endif

    logic [1:0]  state;
    logic        side;
    logic [10:0] size;
    logic [5:0]  u;

    // Span geometry in 12-bit signed so that very wide walls give a negative left edge
    // and a right edge beyond the screen; clipping then falls out of the compares.
    logic signed [11:0] hp;
    logic signed [11:0] left;
    logic signed [11:0] right;
    logic               in_sky;
    logic               in_wall;
    logic [5:0]         wall_rgb;

    assign hp      = $signed({2'b00, hpos});
    assign left    = $signed({2'b00, CENTRE}) - $signed({2'b00, size[10:1]});
    assign right   = left + $signed({1'b0, size});
    assign in_sky  = hp < left;
    assign in_wall = (state != S_IDLE) && !in_sky && (hp < right);

`ifdef ROW_RENDER_TEXTURE_EN
    // step = floor(65536 / size) as UQ7.10, built MSB first by restoring division.
    // The dividend is a single 1 followed by sixteen 0s, so its bit is (cnt == 16).
    logic [16:0] step;
    logic [11:0] rem;
    logic [4:0]  cnt;
    logic [15:0] acc;
    logic [11:0] r_sh;
    logic [11:0] r_diff;
    logic        r_ge;
    logic [15:0] s16;
    logic [15:0] seed;
    logic        at_seed;
    logic        run_now;
    logic [15:0] acc_cur;
    logic        unused_tex;

    assign r_sh   = {rem[10:0], (cnt == 5'd16)};
    assign r_diff = r_sh - {1'b0, size};
    assign r_ge   = r_sh >= {1'b0, size};

    // acc wraps modulo 64.0, so only step[15:0] matters for both the seed and the add.
    // seed = 32.0 - 296*step, with 296 = 256 + 32 + 8.
    assign s16  = step[15:0];
    assign seed = 16'h8000 - {s16[7:0], 8'h00} - {s16[10:0], 5'h00} - {s16[12:0], 3'h0};

    // The seed column itself is already textured: on that cycle the seed value addresses
    // the ROM directly, and acc is loaded one step ahead so that in RUN it always holds
    // the value for the current column (acc = 32.0 exactly at CENTRE).
    assign at_seed = (hpos == SEED_COL);
    assign run_now = (state == S_RUN) || ((state == S_SEED) && at_seed);
    assign acc_cur = (state == S_SEED) ? seed : acc;
    assign o_tex_u = u;
    assign o_tex_v = run_now ? acc_cur[15:10] : 6'd0;

    always_comb begin
        wall_rgb = side ? WALL1_RGB : WALL0_RGB;
        if (run_now) begin
            wall_rgb = side ? {1'b0, i_texel[5], 1'b0, i_texel[3], 1'b0, i_texel[1]} : i_texel;
        end
    end

    assign unused_tex = &{1'b0, step[16], rem[11]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            side  <= 1'b0;
            size  <= 11'd0;
            u     <= 6'd0;
            step  <= 17'd0;
            rem   <= 12'd0;
            cnt   <= 5'd0;
            acc   <= 16'd0;
        end else if (hmax) begin
            side  <= i_side;
            size  <= i_size;
            u     <= i_tex_u;
            step  <= 17'd0;
            rem   <= 12'd0;
            cnt   <= 5'd16;
            state <= (i_size != 11'd0) ? S_DIV : S_IDLE;
        end else begin
            case (state)
                S_DIV: begin
                    step <= {step[15:0], r_ge};
                    rem  <= r_ge ? r_diff : r_sh;
                    if (cnt == 5'd0) begin
                        state <= S_SEED;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                S_SEED: begin
                    if (at_seed) begin
                        acc   <= seed + s16;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc <= acc + s16;
                end
                default: begin
                end
            endcase
        end
    end
`else
    logic unused_flat;

    assign o_tex_u     = 6'd0;
    assign o_tex_v     = 6'd0;
    assign wall_rgb    = side ? WALL1_RGB : WALL0_RGB;
    assign unused_flat = &{1'b0, u, i_texel};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            side  <= 1'b0;
            size  <= 11'd0;
            u     <= 6'd0;
        end else if (hmax) begin
            side  <= i_side;
            size  <= i_size;
            u     <= i_tex_u;
            state <= (i_size != 11'd0) ? S_WALL : S_IDLE;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            o_rgb <= 6'd0;
        end else if (!visible) begin
            o_rgb <= 6'd0;
        end else if (in_sky) begin
            o_rgb <= SKY_RGB;
        end else if (!in_wall) begin
            o_rgb <= FLOOR_RGB;
        end else begin
            o_rgb <= wall_rgb;
        end
    end

endmodule

// File: tb/tb_row_render.sv
// tb_row_render: directed scanline checks for row_render (reset, textured/flat spans, background, wide walls).
// Latency: pixel colour checked one clock after its hpos; ROM address checked in the same cycle.
// Backpressure: none; the bench drives hpos/hmax directly.

module tb_row_render;

`ifdef ROW_RENDER_TEXTURE_EN
    localparam bit TEX_ON = 1'b1;
`else
    localparam bit TEX_ON = 1'b0;
`endif

    localparam logic [5:0] SKY   = 6'b00_00_01;
    localparam logic [5:0] FLOOR = 6'b01_01_01;
    localparam logic [5:0] WALL0 = 6'b11_00_00;
    localparam logic [5:0] WALL1 = 6'b01_00_00;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  hpos;
    logic        visible;
    logic        hmax;
    logic        i_side;
    logic [10:0] i_size;
    logic [5:0]  i_tex_u;
    logic [5:0]  i_texel;
    logic [5:0]  o_tex_u;
    logic [5:0]  o_tex_v;
    logic [5:0]  o_rgb;

    int n_vec = 0;
    int n_bad = 0;

    // Texture ROM whose texel equals its row; in the flat build it returns a fixed
    // pattern that must never reach the output.
`ifdef ROW_RENDER_TEXTURE_EN
    assign i_texel = o_tex_v;
`else
    assign i_texel = 6'h2A;
`endif

    always #5 clk = ~clk;

    row_render dut (
        .clk     (clk),
        .reset   (reset),
        .hpos    (hpos),
        .visible (visible),
        .hmax    (hmax),
        .i_side  (i_side),
        .i_size  (i_size),
        .i_tex_u (i_tex_u),
        .i_texel (i_texel),
        .o_tex_u (o_tex_u),
        .o_tex_v (o_tex_v),
        .o_rgb   (o_rgb)
    );

    // Expected texture row: acc is 32.0 at column 320 and advances by step per column;
    // before column 24 the accumulator is not yet seeded and the row address is 0.
    function automatic logic [5:0] exp_v(input int h, input int size, input int step);
        if (!TEX_ON || size == 0 || h < 24) return 6'd0;
        return 6'(((32768 + (h - 320) * step) & 65535) >> 10);
    endfunction

    function automatic logic [5:0] exp_rgb(input int h, input int side, input int size, input int step);
        int left;
        int right;
        logic [5:0] v;
        left  = 320 - size / 2;
        right = left + size;
        if (h < left) return SKY;
        if (h >= right) return FLOOR;
        if (!TEX_ON || h < 24) return (side != 0) ? WALL1 : WALL0;
        v = exp_v(h, size, step);
        return (side != 0) ? {1'b0, v[5], 1'b0, v[3], 1'b0, v[1]} : v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_hmax(input logic side, input logic [10:0] size, input logic [5:0] u);
        hpos    = 10'd799;
        visible = 1'b0;
        hmax    = 1'b1;
        i_side  = side;
        i_size  = size;
        i_tex_u = u;
        tick;
        hmax    = 1'b0;
        i_side  = 1'b0;
        i_size  = 11'd0;
        i_tex_u = 6'd0;
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        hmax    = 1'b0;
        hpos    = 10'd100;
        visible = 1'b1;
        i_side  = 1'b1;
        i_size  = 11'd64;
        i_tex_u = 6'd9;
        tick;
        tick;
        n_vec++; if (o_rgb !== 6'd0) begin n_bad++; $display("FAIL reset_rgb got %0d want 0", o_rgb); end
        n_vec++; if (o_tex_u !== 6'd0) begin n_bad++; $display("FAIL reset_tex_u got %0d want 0", o_tex_u); end
        n_vec++; if (o_tex_v !== 6'd0) begin n_bad++; $display("FAIL reset_tex_v got %0d want 0", o_tex_v); end
        reset = 1'b0;
    endtask

    task automatic test_size64;
        logic [5:0] ev;
        logic [5:0] er;
        // A second hmax three clocks into the first divide must restart from scratch.
        do_hmax(1'b1, 11'd128, 6'd3);
        tick; tick; tick;
        do_hmax(1'b0, 11'd64, 6'd17);
        n_vec++; if (o_rgb !== 6'd0) begin n_bad++; $display("FAIL s64_blank got %0d want 0", o_rgb); end
        n_vec++; if (o_tex_u !== (TEX_ON ? 6'd17 : 6'd0)) begin n_bad++; $display("FAIL s64_tex_u got %0d want %0d", o_tex_u, TEX_ON ? 17 : 0); end
        for (int h = 0; h < 640; h++) begin
            hpos = 10'(h); visible = 1'b1; #1;
            ev = exp_v(h, 64, 1024);
            er = exp_rgb(h, 0, 64, 1024);
            n_vec++; if (o_tex_v !== ev) begin n_bad++; $display("FAIL s64_tex_v h=%0d got %0d want %0d", h, o_tex_v, ev); end
            tick;
            n_vec++; if (o_rgb !== er) begin n_bad++; $display("FAIL s64_rgb h=%0d got %0d want %0d", h, o_rgb, er); end
        end
    endtask

    task automatic test_size128_side1;
        logic [5:0] ev;
        logic [5:0] er;
        do_hmax(1'b1, 11'd128, 6'd40);
        for (int h = 0; h < 640; h++) begin
            hpos = 10'(h); visible = 1'b1; #1;
            ev = exp_v(h, 128, 512);
            er = exp_rgb(h, 1, 128, 512);
            n_vec++; if (o_tex_v !== ev) begin n_bad++; $display("FAIL s128_tex_v h=%0d got %0d want %0d", h, o_tex_v, ev); end
            tick;
            n_vec++; if (o_rgb !== er) begin n_bad++; $display("FAIL s128_rgb h=%0d got %0d want %0d", h, o_rgb, er); end
        end
    endtask

    task automatic test_no_wall;
        logic [5:0] er;
        do_hmax(1'b0, 11'd0, 6'd5);
        for (int h = 0; h < 640; h++) begin
            hpos = 10'(h); visible = 1'b1; #1;
            er = (h < 320) ? SKY : FLOOR;
            n_vec++; if (o_tex_v !== 6'd0) begin n_bad++; $display("FAIL s0_tex_v h=%0d got %0d want 0", h, o_tex_v); end
            tick;
            n_vec++; if (o_rgb !== er) begin n_bad++; $display("FAIL s0_rgb h=%0d got %0d want %0d", h, o_rgb, er); end
        end
        // Outside the active area the output is black.
        hpos = 10'd700; visible = 1'b0;
        tick;
        n_vec++; if (o_rgb !== 6'd0) begin n_bad++; $display("FAIL s0_blank got %0d want 0", o_rgb); end
    endtask

    task automatic test_wide;
        logic [5:0] ev;
        logic [5:0] er;
        do_hmax(1'b1, 11'd1000, 6'd0);
        for (int h = 0; h < 640; h++) begin
            hpos = 10'(h); visible = 1'b1; #1;
            ev = exp_v(h, 1000, 65);
            er = exp_rgb(h, 1, 1000, 65);
            n_vec++; if (o_tex_v !== ev) begin n_bad++; $display("FAIL wide_tex_v h=%0d got %0d want %0d", h, o_tex_v, ev); end
            tick;
            n_vec++; if (o_rgb !== er) begin n_bad++; $display("FAIL wide_rgb h=%0d got %0d want %0d", h, o_rgb, er); end
        end
    endtask

    task automatic test_reset_midline;
        logic [5:0] er;
        do_hmax(1'b0, 11'd64, 6'd8);
        for (int h = 0; h < 300; h++) begin
            hpos = 10'(h); visible = 1'b1;
            tick;
        end
        hpos = 10'd300; visible = 1'b1; reset = 1'b1;
        tick;
        reset = 1'b0;
        n_vec++; if (o_rgb !== 6'd0) begin n_bad++; $display("FAIL rst_mid_rgb got %0d want 0", o_rgb); end
        for (int h = 301; h < 640; h++) begin
            hpos = 10'(h); visible = 1'b1; #1;
            er = (h < 320) ? SKY : FLOOR;
            n_vec++; if (o_tex_v !== 6'd0) begin n_bad++; $display("FAIL rst_mid_tex_v h=%0d got %0d want 0", h, o_tex_v); end
            tick;
            n_vec++; if (o_rgb !== er) begin n_bad++; $display("FAIL rst_mid_rgb h=%0d got %0d want %0d", h, o_rgb, er); end
        end
    endtask

    initial begin
        test_reset;
        test_size64;
        test_size128_side1;
        test_no_wall;
        test_wide;
        test_reset_midline;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
